// File: rtl/frame_tick_gen.sv
// frame_tick_gen: detects the frame boundary on row_addr and derives NCH divided tick/toggle streams
module frame_tick_gen #(
  parameter int ROW_W    = 9,
  parameter int TRIG_ROW = 511,
  parameter int NCH      = 4,
  parameter int DIV_W    = 8,
  parameter int FCNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ROW_W-1:0]       row_addr,
  input  logic [NCH-1:0]         en,
  input  logic [NCH-1:0]         clr,
  input  logic [NCH*DIV_W-1:0]   div,
  output logic                   frame_tick,
  output logic [NCH-1:0]         tick,
  output logic [NCH-1:0]         tog,
  output logic [FCNT_W-1:0]      frame_cnt
);
  localparam logic [ROW_W-1:0] TRIG = ROW_W'(TRIG_ROW);
  logic [ROW_W-1:0]            la_row_q;
  logic                        frame_tick_q;
  logic [FCNT_W-1:0]           frame_cnt_q;
  logic [NCH-1:0][DIV_W-1:0]   cnt_q, cnt_d;
  logic [NCH-1:0]              tick_q, tick_d, tog_q, tog_d;
  logic                        hit, adv, wrap;
  logic [DIV_W-1:0]            lim;
  assign hit = (row_addr == TRIG) && (la_row_q != TRIG);
  // A zero ratio behaves as one, so the wrap limit never underflows
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = '0;
    tog_d  = tog_q;
    lim    = '0;
    adv    = 1'b0;
    wrap   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      lim       = (div[i*DIV_W +: DIV_W] == '0) ? '0 : div[i*DIV_W +: DIV_W] - 1'b1;
      adv       = hit && en[i];
      wrap      = adv && (cnt_q[i] >= lim);
      cnt_d[i]  = (clr[i] || wrap) ? '0 : adv ? cnt_q[i] + 1'b1 : cnt_q[i];
      tick_d[i] = !clr[i] && wrap;
      tog_d[i]  = !clr[i] && (tog_q[i] ^ wrap);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      la_row_q     <= TRIG;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
      cnt_q        <= '0;
      tick_q       <= '0;
      tog_q        <= '0;
    end else begin
      la_row_q     <= row_addr;
      frame_tick_q <= hit;
      frame_cnt_q  <= hit ? frame_cnt_q + 1'b1 : frame_cnt_q;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      tog_q        <= tog_d;
    end
  end
  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;
  assign tick       = tick_q;
  assign tog        = tog_q;
endmodule

// File: tb/tb_frame_tick_gen.sv
// tb_frame_tick_gen: randomized and directed checks against a frame-counting reference model
module tb_frame_tick_gen;
  localparam int NCH = 4, DIV_W = 8, TRIG = 511;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [8:0] row_addr = 9'd511;
  logic [NCH-1:0] en = '0, clr = '0;
  logic [NCH*DIV_W-1:0] div = '0;
  logic frame_tick;
  logic [NCH-1:0] tick, tog;
  logic [15:0] frame_cnt;
  int checks = 0, errors = 0;
  int prev_row = TRIG;
  int frames_seen [NCH];
  logic exp_ft;
  logic [15:0] exp_fc;
  logic [NCH-1:0] exp_tick, exp_tog;

  frame_tick_gen dut (.clk(clk), .rst_n(rst_n), .row_addr(row_addr), .en(en), .clr(clr),
    .div(div), .frame_tick(frame_tick), .tick(tick), .tog(tog), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  task automatic model_reset();
    prev_row = TRIG; exp_ft = 0; exp_fc = 0; exp_tick = '0; exp_tog = '0;
    for (int i = 0; i < NCH; i++) frames_seen[i] = 0;
  endtask

  // Advance one clock; the model counts enabled frames since the last period end
  task automatic cyc();
    bit h;
    int d;
    if (!rst_n) model_reset();
    else begin
      h = (int'(row_addr) == TRIG) && (prev_row != TRIG);
      exp_ft = h;
      if (h) exp_fc = exp_fc + 16'd1;
      for (int i = 0; i < NCH; i++) begin
        d = int'(div[i*DIV_W +: DIV_W]);
        if (d == 0) d = 1;
        exp_tick[i] = 0;
        if (clr[i]) begin
          frames_seen[i] = 0; exp_tog[i] = 0;
        end else if (h && en[i]) begin
          frames_seen[i]++;
          if (frames_seen[i] >= d) begin
            frames_seen[i] = 0; exp_tick[i] = 1; exp_tog[i] = ~exp_tog[i];
          end
        end
      end
      prev_row = int'(row_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic frame();
    row_addr = 9'd0; cyc();
    row_addr = 9'd511; cyc();
  endtask

  task automatic set_div(input int ch, input int v);
    div[ch*DIV_W +: DIV_W] = DIV_W'(v);
  endtask

  task automatic test_reset();
    int pulses = 0;
    rst_n = 0; row_addr = 9'd511; model_reset();
    #12;
    checks++;
    if (frame_tick !== 1'b0 || tick !== '0 || tog !== '0 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_outputs got ft=%b tick=%b tog=%b fc=%0d want all 0", frame_tick, tick, tog, frame_cnt);
    end
    @(negedge clk); rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      cyc(); checks++;
      if (frame_tick !== 1'b0) begin errors++; $display("FAIL hold_trig_ft cycle %0d got %b want 0", k, frame_tick); end
    end
    for (int r = 0; r < 512; r++) begin
      row_addr = 9'(r); cyc();
      if (frame_tick) pulses++;
      checks++;
      if (frame_tick !== exp_ft) begin errors++; $display("FAIL sweep_ft row %0d got %b want %b", r, frame_tick, exp_ft); end
    end
    for (int k = 0; k < 3; k++) begin cyc(); if (frame_tick) pulses++; end
    checks++;
    if (pulses != 1 || frame_cnt !== 16'd1) begin
      errors++; $display("FAIL sweep_count got pulses=%0d fc=%0d want 1 1", pulses, frame_cnt);
    end
  endtask

  task automatic test_div1();
    set_div(0, 1); en = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      frame(); checks++;
      if (tick[0] !== 1'b1 || tog[0] !== ((k % 2) == 0) || tick !== exp_tick || frame_tick !== 1'b1) begin
        errors++; $display("FAIL div1 frame %0d got tick=%b tog0=%b ft=%b want tick0=1 tog0=%0d", k, tick, tog[0], frame_tick, (k % 2) == 0);
      end
    end
  endtask

  task automatic test_div3();
    clr = 4'b0010; cyc(); clr = '0;
    set_div(1, 3); en = 4'b0010;
    for (int k = 1; k <= 9; k++) begin
      frame(); checks++;
      if (tick[1] !== ((k % 3) == 0) || tog !== exp_tog || frame_cnt !== exp_fc) begin
        errors++; $display("FAIL div3 frame %0d got tick1=%b tog=%b fc=%0d want tick1=%0d tog=%b fc=%0d", k, tick[1], tog, frame_cnt, (k % 3) == 0, exp_tog, exp_fc);
      end
    end
    checks++;
    if (tog[1] !== 1'b1) begin errors++; $display("FAIL div3_final_tog got %b want 1", tog[1]); end
  endtask

  task automatic test_div0();
    clr = 4'b1100; cyc(); clr = '0;
    set_div(2, 0); set_div(3, 3); en = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      frame(); checks++;
      if (tick[2] !== 1'b1 || tog[2] !== ((k % 2) == 0) || tick[3] !== 1'b0 || tog[3] !== 1'b0) begin
        errors++; $display("FAIL div0 frame %0d got tick=%b tog=%b want tick2=1 tog2=%0d ch3=0", k, tick, tog, (k % 2) == 0);
      end
    end
  endtask

  task automatic test_clr();
    en = 4'b0010; set_div(1, 4);
    clr = 4'b0010; cyc(); clr = '0;
    frame(); frame();
    clr = 4'b0010; cyc(); clr = '0;
    checks++;
    if (tog[1] !== 1'b0 || tick[1] !== 1'b0) begin errors++; $display("FAIL clr_state got tick1=%b tog1=%b want 0 0", tick[1], tog[1]); end
    for (int k = 1; k <= 4; k++) begin
      frame(); checks++;
      if (tick[1] !== (k == 4) || tog !== exp_tog) begin
        errors++; $display("FAIL clr_restart frame %0d got tick1=%b tog=%b want tick1=%0d tog=%b", k, tick[1], tog, k == 4, exp_tog);
      end
    end
    frame(); frame(); frame();
    set_div(1, 2); frame(); checks++;
    if (tick[1] !== 1'b1 || tick !== exp_tick) begin errors++; $display("FAIL div_lowered got tick=%b want tick1=1", tick); end
    en = '0; frame(); en = 4'b0010; frame(); checks++;
    if (tick[1] !== 1'b0) begin errors++; $display("FAIL en_freeze got tick1=%b want 0", tick[1]); end
    frame(); checks++;
    if (tick[1] !== 1'b1) begin errors++; $display("FAIL en_resume got tick1=%b want 1", tick[1]); end
    row_addr = 9'd0; cyc();
    clr = 4'b0010; row_addr = 9'd511; cyc(); clr = '0; checks++;
    if (frame_tick !== 1'b1 || tick[1] !== 1'b0 || tog[1] !== 1'b0) begin
      errors++; $display("FAIL clr_with_hit got ft=%b tick1=%b tog1=%b want 1 0 0", frame_tick, tick[1], tog[1]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 3))
        0: row_addr = 9'd511;
        1: row_addr = 9'd0;
        default: row_addr = 9'($urandom);
      endcase
      en = 4'($urandom);
      clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : '0;
      if ($urandom_range(0, 19) == 0)
        for (int i = 0; i < NCH; i++) set_div(i, $urandom_range(0, 5));
      cyc(); checks++;
      if (frame_tick !== exp_ft || tick !== exp_tick || tog !== exp_tog || frame_cnt !== exp_fc) begin
        errors++; $display("FAIL random cycle %0d got ft=%b tick=%b tog=%b fc=%0d want ft=%b tick=%b tog=%b fc=%0d", k, frame_tick, tick, tog, frame_cnt, exp_ft, exp_tick, exp_tog, exp_fc);
      end
    end
    clr = '0;
  endtask

  task automatic test_async_reset();
    en = 4'b0010; set_div(1, 4);
    clr = 4'b0010; cyc(); clr = '0;
    for (int k = 0; k < 6; k++) frame();
    checks++;
    if (tog[1] !== 1'b1 || frames_seen[1] != 2) begin errors++; $display("FAIL pre_reset_state got tog1=%b want 1", tog[1]); end
    @(negedge clk); rst_n = 0; #1;
    checks++;
    if (frame_tick !== 1'b0 || tick !== '0 || tog !== '0 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL async_reset got ft=%b tick=%b tog=%b fc=%0d want all 0", frame_tick, tick, tog, frame_cnt);
    end
    model_reset();
    @(negedge clk); rst_n = 1; row_addr = 9'd511;
    for (int k = 0; k < 3; k++) begin
      cyc(); checks++;
      if (frame_tick !== 1'b0 || tick !== '0 || tog !== '0) begin
        errors++; $display("FAIL post_reset cycle %0d got ft=%b tick=%b tog=%b want 0", k, frame_tick, tick, tog);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      frame(); checks++;
      if (tick[1] !== (k == 4)) begin errors++; $display("FAIL post_reset_period frame %0d got tick1=%b want %0d", k, tick[1], k == 4); end
    end
  endtask

  initial begin
    test_reset();
    test_div1();
    test_div3();
    test_div0();
    test_clr();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
